// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg: shared types and constants for the register-file write-back unit.
//
// Contents:
//   WB_FIFO_DEPTH_DEFAULT  default number of LSU buffer entries
//   WB_WIDTH / WB_ADDR_WIDTH  default data / register-address widths
//   wb_entry_t             buffered write {live, addr, data}
//
// WORD_WIDTH and REG_COUNT normally come from constants.svh; if that header
// has not been included ahead of this file, the fallback values below apply.
// ---------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

package wb_pkg;

   localparam int WB_FIFO_DEPTH_DEFAULT = 4;
   localparam int WB_WIDTH              = `WORD_WIDTH;
   localparam int WB_ADDR_WIDTH         = $clog2(`REG_COUNT);

   // Buffered LSU write; live is cleared when a younger ALU write to the
   // same register overtakes it.
   typedef struct packed {
      logic                     live;
      logic [WB_ADDR_WIDTH-1:0] addr;
      logic [WB_WIDTH-1:0]      data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo: circular buffer of pending LSU writes with a clear-by-address
// port that marks matching entries dead without removing them.
//
// Optional feature macro: WB_FWD_EN (adds the youngest-first lookup port).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   push_i, push_addr_i/data_i write a new live entry at the tail
//   pop_i                      drop the head entry
//   kill_i, kill_addr_i        clear live on every entry with that address,
//                              including one pushed in the same cycle
//   full_o, empty_o            occupancy flags from the registered count
//   head_live_o/addr_o/data_o  current head entry
//   fwd_addr_i                 (WB_FWD_EN) lookup address
//   fwd_hit_o, fwd_data_o      (WB_FWD_EN) youngest live match
// ---------------------------------------------------------------------------
module wb_fifo
   import wb_pkg::*;
#(
   parameter int WIDTH      = WB_WIDTH,
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int DEPTH      = WB_FIFO_DEPTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [ADDR_WIDTH-1:0] push_addr_i,
   input  logic [WIDTH-1:0]      push_data_i,
   input  logic                  pop_i,
   input  logic                  kill_i,
   input  logic [ADDR_WIDTH-1:0] kill_addr_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  head_live_o,
   output logic [ADDR_WIDTH-1:0] head_addr_o,
   output logic [WIDTH-1:0]      head_data_o
`ifdef WB_FWD_EN
   ,
   input  logic [ADDR_WIDTH-1:0] fwd_addr_i,
   output logic                  fwd_hit_o,
   output logic [WIDTH-1:0]      fwd_data_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [DEPTH-1:0]      live_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
   logic [WIDTH-1:0]      mem_data_q [DEPTH];

   // Control state: pointers, count and live flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         live_q   <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && (mem_addr_q[i] == kill_addr_i)) live_q[i] <= 1'b0;
         end
         // Written after the kill loop so a same-cycle push sees the kill too.
         if (push_i) live_q[wr_ptr_q] <= !(kill_i && (push_addr_i == kill_addr_i));
      end
   end

   // Payload storage is not reset; live_q and count_q qualify it.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_addr_q[wr_ptr_q] <= push_addr_i;
         mem_data_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign full_o      = (count_q == CNT_W'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign head_live_o = live_q[rd_ptr_q];
   assign head_addr_o = mem_addr_q[rd_ptr_q];
   assign head_data_o = mem_data_q[rd_ptr_q];

`ifdef WB_FWD_EN
   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest over occupied slots; a later match overrides,
   // so the youngest live entry wins.
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
      idx        = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && live_q[idx] && (mem_addr_q[idx] == fwd_addr_i)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = mem_data_q[idx];
         end
      end
   end
`endif

endmodule

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback: merges ALU results (always accepted) and buffered LSU
// load results into the single register-file write port, one write per
// cycle, keeping program order per register.
//
// Optional feature macro: WB_FWD_EN (forwarding lookup ports fwd_*).
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   alu_valid, alu_addr, alu_data      ALU result, no back-pressure
//   lsu_valid, lsu_ready, lsu_addr, lsu_data  LSU result handshake
//   addr_d, we_d, d                    registered write port to regfile
//   wb_idle                            nothing buffered and no write pending
//   fwd_addr, fwd_hit, fwd_data        (WB_FWD_EN) youngest pending write
// ---------------------------------------------------------------------------
module regfile_writeback
   import wb_pkg::*;
#(
   parameter int WIDTH      = `WORD_WIDTH,
   parameter int REG_COUNT  = `REG_COUNT,
   parameter int FIFO_DEPTH = WB_FIFO_DEPTH_DEFAULT,
   localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [WIDTH-1:0]      alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic [WIDTH-1:0]      lsu_data,
   output logic [ADDR_WIDTH-1:0] addr_d,
   output logic                  we_d,
   output logic [WIDTH-1:0]      d,
   output logic                  wb_idle
`ifdef WB_FWD_EN
   ,
   input  logic [ADDR_WIDTH-1:0] fwd_addr,
   output logic                  fwd_hit,
   output logic [WIDTH-1:0]      fwd_data
`endif
);

   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  head_live;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [WIDTH-1:0]      head_data;

   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WIDTH-1:0]      data_q;

   // ALU has priority over the buffer, so the FIFO only drains in ALU bubbles.
   assign push = lsu_valid && !full;
   assign pop  = !alu_valid && !empty;

`ifdef WB_FWD_EN
   logic                  fifo_hit;
   logic [WIDTH-1:0]      fifo_data;
`endif

   wb_fifo #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_addr_i (lsu_addr),
      .push_data_i (lsu_data),
      .pop_i       (pop),
      .kill_i      (alu_valid),
      .kill_addr_i (alu_addr),
      .full_o      (full),
      .empty_o     (empty),
      .head_live_o (head_live),
      .head_addr_o (head_addr),
      .head_data_o (head_data)
`ifdef WB_FWD_EN
      ,
      .fwd_addr_i  (fwd_addr),
      .fwd_hit_o   (fifo_hit),
      .fwd_data_o  (fifo_data)
`endif
   );

   // Output stage; a dead head pops as a bubble (we low) but still loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else if (alu_valid) begin
         we_q   <= 1'b1;
         addr_q <= alu_addr;
         data_q <= alu_data;
      end else if (!empty) begin
         we_q   <= head_live;
         addr_q <= head_addr;
         data_q <= head_data;
      end else begin
         we_q   <= 1'b0;
      end
   end

   assign addr_d    = addr_q;
   assign we_d      = we_q;
   assign d         = data_q;
   assign lsu_ready = !full;
   assign wb_idle   = empty && !we_q;

`ifdef WB_FWD_EN
   // Buffered entries are younger than the output stage, so they win.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (fifo_hit) begin
         fwd_hit  = 1'b1;
         fwd_data = fifo_data;
      end else if (we_q && (addr_q == fwd_addr)) begin
         fwd_hit  = 1'b1;
         fwd_data = data_q;
      end
   end
`endif

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back unit for the register file write port. It merges results from the ALU (always accepted) and the load/store unit (valid/ready, buffered in a small FIFO) into the single write port `addr_d`/`we_d`/`d`. It commits at most one write per cycle and preserves program order per register. It sits between the execute/memory stages and `regfile`.

## Interface
- `WIDTH`, default `WORD_WIDTH`: data word width.
- `REG_COUNT`, default `REG_COUNT`: number of registers. `ADDR_WIDTH = $clog2(REG_COUNT)`.
- `FIFO_DEPTH`, default 4: LSU buffer entries; power of two, ≥2.
- Clock is `clk` and reset is `rst_n`, asynchronous active-low; one clock domain.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_valid`  in  1  ALU result present this cycle; always accepted, no ready.
- `alu_addr`  in  ADDR_WIDTH  ALU destination register.
- `alu_data`  in  WIDTH  ALU result.
- `lsu_valid`  in  1  LSU load result offered.
- `lsu_ready`  out  1  FIFO can accept an entry; `= !full`, from registered count only.
- `lsu_addr`  in  ADDR_WIDTH  LSU destination register.
- `lsu_data`  in  WIDTH  LSU load data.
- `addr_d`  out  ADDR_WIDTH  to `regfile`; registered.
- `we_d`  out  1  to `regfile`; registered.
- `d`  out  WIDTH  to `regfile`; registered.
- `wb_idle`  out  1  FIFO empty and `we_d` low; used for drains and fences.
- `fwd_addr`  in  ADDR_WIDTH  forwarding lookup address; only with `WB_FWD_EN`.
- `fwd_hit`  out  1  pending write to `fwd_addr` exists; only with `WB_FWD_EN`.
- `fwd_data`  out  WIDTH  value of the youngest pending write; only with `WB_FWD_EN`.

## Operation
- Push: LSU entry `{addr, data, live=1}` is written at the FIFO tail when `lsu_valid && lsu_ready`.
- Select, per cycle:
  - If `alu_valid`, the output stage loads the ALU result and `we_d` goes to 1.
  - Otherwise, if the FIFO is non-empty, the head is popped. The output loads it with `we_d = head.live`; a dead entry pops as a bubble with `we_d = 0`.
  - Otherwise `we_d` goes to 0. `addr_d` and `d` hold their last values.
- Kill: when `alu_valid`, every FIFO entry whose addr equals `alu_addr` has `live` cleared. This includes an entry pushed in the same cycle. The LSU result is older in program order than any simultaneous ALU result.
- A killed entry still occupies its slot until it is popped.
- Full: `lsu_ready = 0` when count equals `FIFO_DEPTH`. A pop in the same cycle does not enable a push.
- Simultaneous push and pop: count is unchanged and pointers wrap modulo `FIFO_DEPTH`.
- No starvation guarantee: back-to-back ALU results stall the FIFO indefinitely. The upstream pipeline provides bubbles.
- Register 0 gets no special treatment; `regfile` owns that semantics.

## Timing
- Reset (async assert, sync-safe deassert): FIFO empty, all `live` flags 0, `addr_d = 0`, `d = 0`, `we_d = 0`, `lsu_ready = 1`, `wb_idle = 1`.
- Reset mid-operation discards all pending entries.
- ALU latency: sampled at edge N, `we_d` is high during cycle N+1, and `regfile` commits at edge N+1.
- LSU minimum latency: pushed at edge N, popped at edge N+1, `we_d` high during cycle N+2.
- Throughput: one write per cycle.
- `fwd_*` outputs are combinational from `fwd_addr` and the registered state.

## Configuration
- Macro: `WB_FWD_EN`.
- With the macro defined:
  - `fwd_*` ports exist.
  - Search order is live FIFO entries from youngest to oldest, then the output stage if `we_d = 1`.
  - The first match sets `fwd_hit = 1` and drives `fwd_data`. With no match, `fwd_hit = 0` and `fwd_data = 0`.
- Without the macro: `fwd_*` ports and the lookup logic are absent; all other behaviour is identical.

## Structure
- Shared package `wb_pkg` holds `wb_entry_t` (`{live, addr, data}`, parameterised via `WIDTH` and `ADDR_WIDTH`) and `WB_FIFO_DEPTH_DEFAULT`.
- `WORD_WIDTH` and `REG_COUNT` continue to come from `constants.svh`.
- One sub-module, `wb_fifo`: circular buffer with a per-entry `live` clear-by-address port, `full`/`empty`/`count`, and entry visibility for forwarding.
- Top level contains the select logic and the output register.

## Test plan
- Reset: after reset, `we_d = 0`, `lsu_ready = 1`, `wb_idle = 1`. ALU write `{5, 0xAA}` gives `we_d = 1`, `addr_d = 5`, `d = 0xAA` one cycle later, then reading `regfile` port A at 5 returns `0xAA`.
- Ordering: LSU `{3, 0x11}` at cycle 0 and ALU `{3, 0x22}` at cycle 1. The ALU write commits and the LSU entry pops as a bubble, so register 3 ends at `0x22`.
- Same-cycle hazard: LSU `{7, 0x1}` and ALU `{7, 0x2}` in the same cycle end with register 7 at `0x2`. With different addresses, both commit, ALU first.
- Full: hold `alu_valid` high and push 4 LSU entries (`FIFO_DEPTH = 4`). `lsu_ready` drops after the 4th push. Releasing the ALU drains the FIFO in order at 1 per cycle, and `wb_idle` rises one cycle after the last write.
- Reset mid-operation: 3 entries pending, then assert `rst_n = 0`. The FIFO is empty, `we_d = 0` immediately, and no pending writes reach `regfile`.
- `WB_FWD_EN`: pending LSU entries `{9, 0x5}` and `{9, 0x6}` give `fwd_addr = 9` → `fwd_hit = 1`, `fwd_data = 0x6`. `fwd_addr = 10` → `fwd_hit = 0`.
